temp_read_sequencer: RTL and testbench

Sequences the byte-level I2C master to read the 16-bit temperature register of the on-board sensor. Issues a pointer write followed by a repeated-start two-byte read, assembles MSB:LSB and presents the result with a valid strobe to the 7-segment display path. Triggers periodically or on demand. Handles NACK and timeout with abort and a sticky error flag.

---
 rtl/temp_read_sequencer_if.sv | 21 ++
 rtl/temp_read_sequencer.sv | 158 +++++++++++++++
 tb/tb_temp_read_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/temp_read_sequencer_if.sv
// Byte-level I2C master command/response bundle between the temperature
// sequencer (master modport) and the I2C byte engine (slave modport).
interface temp_read_sequencer_if;
   logic       i2c_ena;
   logic [6:0] i2c_addr;
   logic       i2c_rw;
   logic [7:0] i2c_data_wr;
   logic       i2c_busy;
   logic [7:0] i2c_data_rd;
   logic       i2c_ack_error;

   modport master (
      output i2c_ena, i2c_addr, i2c_rw, i2c_data_wr,
      input  i2c_busy, i2c_data_rd, i2c_ack_error
   );

   modport slave (
      input  i2c_ena, i2c_addr, i2c_rw, i2c_data_wr,
      output i2c_busy, i2c_data_rd, i2c_ack_error
   );
endinterface

// File: rtl/temp_read_sequencer.sv
// Reads the sensor's 16-bit temperature register through a byte-level I2C
// master: pointer write, repeated-start two-byte read, periodic or on demand.
//
// state  | meaning
// IDLE   | waiting for start pulse or period trigger
// WR_PTR | pointer-write command queued, waiting for master to latch it
// RD_MSB | read queued; waiting for pointer byte to finish and MSB read latch
// RD_LSB | MSB byte in flight; LSB read latched on next rise
// FINISH | LSB byte in flight; result published on its completion
// ABORT  | NACK or timeout; waiting for master to go idle
module temp_read_sequencer #(
   parameter logic [6:0] SENSOR_ADDR   = 7'h48,
   parameter logic [7:0] PTR_REG       = 8'h00,
   parameter int         SAMPLE_PERIOD = 50_000_000,
   parameter int         TIMEOUT_CYC   = 1_000_000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         auto_en,
   input  logic                         start,
   temp_read_sequencer_if.master        bus,
   output logic [15:0]                  temp,
   output logic                         temp_valid,
   output logic                         temp_err,
   output logic                         seq_busy
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WR_PTR = 3'd1;
   localparam logic [2:0] RD_MSB = 3'd2;
   localparam logic [2:0] RD_LSB = 3'd3;
   localparam logic [2:0] FINISH = 3'd4;
   localparam logic [2:0] ABORT  = 3'd5;

   localparam int PW = $clog2(SAMPLE_PERIOD);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

   logic [2:0]    state;
   logic          busy_q;
   logic          rise;
   logic          fall;
   logic          ena_r;
   logic [PW-1:0] pcnt;
   logic [TW-1:0] tcnt;
   logic [7:0]    msb_hold;
   logic          period_trig;
   logic          trig;

   assign rise        = bus.i2c_busy & ~busy_q;
   assign fall        = ~bus.i2c_busy & busy_q;
   assign period_trig = auto_en && (state == IDLE) && (pcnt == P_LAST);
   assign trig        = start | period_trig;

   // Reset pulls the command valid low immediately, without waiting for the edge.
   assign bus.i2c_ena = ena_r & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt <= '0;
      end else if (!auto_en) begin
         pcnt <= '0;
      end else if (state == IDLE) begin
         pcnt <= period_trig ? '0 : pcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         busy_q          <= 1'b0;
         ena_r           <= 1'b0;
         bus.i2c_addr    <= '0;
         bus.i2c_rw      <= 1'b0;
         bus.i2c_data_wr <= '0;
         tcnt            <= '0;
         msb_hold        <= '0;
         temp            <= '0;
         temp_valid      <= 1'b0;
         temp_err        <= 1'b0;
         seq_busy        <= 1'b0;
      end else begin
         busy_q     <= bus.i2c_busy;
         temp_valid <= 1'b0;
         if (state != IDLE && state != ABORT) tcnt <= tcnt + 1'b1;

         case (state)
            IDLE: begin
               if (trig) begin
                  bus.i2c_addr    <= SENSOR_ADDR;
                  bus.i2c_rw      <= 1'b0;
                  bus.i2c_data_wr <= PTR_REG;
                  ena_r           <= 1'b1;
                  seq_busy        <= 1'b1;
                  tcnt            <= '0;
                  state           <= WR_PTR;
               end
            end

            ABORT: begin
               if (!bus.i2c_busy || tcnt == T_LAST) begin
                  temp_err <= 1'b1;
                  seq_busy <= 1'b0;
                  tcnt     <= '0;
                  state    <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            default: begin
               // A NACKed byte outranks everything else, then the timeout.
               if ((fall && bus.i2c_ack_error) || tcnt == T_LAST) begin
                  ena_r <= 1'b0;
                  tcnt  <= '0;
                  state <= ABORT;
               end else begin
                  case (state)
                     WR_PTR: begin
                        if (rise) begin
                           bus.i2c_rw <= 1'b1;
                           state      <= RD_MSB;
                        end
                     end
                     RD_MSB: begin
                        if (rise) state <= RD_LSB;
                     end
                     RD_LSB: begin
                        if (fall) begin
                           msb_hold <= bus.i2c_data_rd;
                        end else if (rise) begin
                           ena_r <= 1'b0;
                           state <= FINISH;
                        end
                     end
                     FINISH: begin
                        if (fall) begin
                           temp       <= {msb_hold, bus.i2c_data_rd};
                           temp_valid <= 1'b1;
                           temp_err   <= 1'b0;
                           seq_busy   <= 1'b0;
                           state      <= IDLE;
                        end
                     end
                     default: begin
                        ena_r    <= 1'b0;
                        seq_busy <= 1'b0;
                        state    <= IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_temp_read_sequencer.sv
// Directed bench for temp_read_sequencer with a behavioural byte-level
// I2C master model.
module tb_temp_read_sequencer;
   logic        clk = 1'b0;
   logic        reset;
   logic        auto_en;
   logic        start;
   logic [15:0] temp;
   logic        temp_valid;
   logic        temp_err;
   logic        seq_busy;

   temp_read_sequencer_if bus();

   temp_read_sequencer #(
      .SENSOR_ADDR  (7'h48),
      .PTR_REG      (8'h00),
      .SAMPLE_PERIOD(200),
      .TIMEOUT_CYC  (500)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .auto_en   (auto_en),
      .start     (start),
      .bus       (bus),
      .temp      (temp),
      .temp_valid(temp_valid),
      .temp_err  (temp_err),
      .seq_busy  (seq_busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int valid_cnt = 0;

   always @(posedge clk) cyc++;
   always @(negedge clk) if (temp_valid === 1'b1) valid_cnt++;

   int         byte_len = 12;
   int         nack_idx = 99;
   logic [7:0] msb_v = 8'h00;
   logic [7:0] lsb_v = 8'h00;
   bit         hang = 1'b0;
   int         rise_cnt = 0;
   int         last_fall = 0;
   logic [2:0] rw_log = 3'b000;
   logic [6:0] last_addr = 7'h00;

   // Master model: latches a command whenever ena is seen high while idle,
   // runs one byte, and chains the next byte if ena is still high.
   initial begin : bus_model
      int bidx;
      bidx = 0;
      bus.i2c_busy      = 1'b0;
      bus.i2c_data_rd   = 8'h00;
      bus.i2c_ack_error = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.i2c_ena === 1'b1) begin
            rw_log            = {rw_log[1:0], bus.i2c_rw};
            last_addr         = bus.i2c_addr;
            bus.i2c_busy      = 1'b1;
            bus.i2c_ack_error = 1'b0;
            rise_cnt++;
            while (hang) @(negedge clk);
            repeat (byte_len) @(negedge clk);
            bus.i2c_data_rd   = (bidx == 1) ? msb_v : (bidx == 2) ? lsb_v : 8'hEE;
            bus.i2c_ack_error = (bidx == nack_idx);
            bus.i2c_busy      = 1'b0;
            last_fall         = cyc;
            bidx++;
         end else begin
            bidx = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int lim);
      int n;
      n = 0;
      while (temp_valid !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, temp_valid, 1);
   endtask

   task automatic wait_idle(input string tag, input int lim);
      int n;
      n = 0;
      while (seq_busy !== 1'b0 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, seq_busy, 0);
   endtask

   task automatic wait_bus_quiet(input string tag, input int lim);
      int n;
      n = 0;
      while (bus.i2c_busy !== 1'b0 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, bus.i2c_busy, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic idle_gap(input string tag);
      int n;
      n = 0;
      while (seq_busy === 1'b0 && n < 1000) begin
         n++;
         @(negedge clk);
      end
      chk(tag, n, 200);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin : main
      int v0;
      int r0;
      int n;
      int m;
      reset   = 1'b1;
      auto_en = 1'b0;
      start   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ena",   bus.i2c_ena, 0);
      chk("rst_addr",  bus.i2c_addr, 0);
      chk("rst_rw",    bus.i2c_rw, 0);
      chk("rst_wr",    bus.i2c_data_wr, 0);
      chk("rst_temp",  temp, 0);
      chk("rst_valid", temp_valid, 0);
      chk("rst_err",   temp_err, 0);
      chk("rst_sbusy", seq_busy, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // nominal read
      msb_v = 8'h19; lsb_v = 8'h80;
      v0 = valid_cnt; r0 = rise_cnt;
      pulse_start();
      chk("nom_ena",   bus.i2c_ena, 1);
      chk("nom_addr",  bus.i2c_addr, 7'h48);
      chk("nom_ptr",   bus.i2c_data_wr, 8'h00);
      chk("nom_rw0",   bus.i2c_rw, 0);
      chk("nom_sbusy", seq_busy, 1);
      wait_valid("nom_valid", 300);
      chk("nom_lat",   cyc - last_fall, 1);
      chk("nom_temp",  temp, 16'h1980);
      chk("nom_err",   temp_err, 0);
      chk("nom_idle",  seq_busy, 0);
      chk("nom_laddr", last_addr, 7'h48);
      @(negedge clk);
      chk("nom_pulse", temp_valid, 0);
      chk("nom_rwseq", rw_log, 3'b011);
      chk("nom_rises", rise_cnt - r0, 3);
      chk("nom_nval",  valid_cnt - v0, 1);
      wait_bus_quiet("nom_quiet", 100);

      // NACK on first byte, then recovery
      nack_idx = 0;
      v0 = valid_cnt;
      pulse_start();
      wait_idle("nack_done", 300);
      chk("nack_lat",  cyc - last_fall, 2);
      chk("nack_ena",  bus.i2c_ena, 0);
      chk("nack_err",  temp_err, 1);
      chk("nack_temp", temp, 16'h1980);
      @(negedge clk);
      chk("nack_nval", valid_cnt - v0, 0);
      nack_idx = 99;
      msb_v = 8'h1A; lsb_v = 8'h00;
      wait_bus_quiet("nack_quiet", 100);
      pulse_start();
      wait_valid("rec_valid", 300);
      chk("rec_temp", temp, 16'h1A00);
      chk("rec_err",  temp_err, 0);
      wait_bus_quiet("rec_quiet", 100);

      // start pulse while already reading is dropped
      msb_v = 8'h21; lsb_v = 8'h40;
      v0 = valid_cnt; r0 = rise_cnt;
      pulse_start();
      repeat (3) @(negedge clk);
      pulse_start();
      wait_valid("ign_valid", 300);
      repeat (60) @(negedge clk);
      chk("ign_rises", rise_cnt - r0, 3);
      chk("ign_nval",  valid_cnt - v0, 1);
      chk("ign_temp",  temp, 16'h2140);

      // periodic reads
      msb_v = 8'h0F; lsb_v = 8'hF0;
      v0 = valid_cnt;
      auto_en = 1'b1;
      wait_valid("per_v1", 400);
      idle_gap("per_gap1");
      wait_valid("per_v2", 400);
      idle_gap("per_gap2");
      auto_en = 1'b0;
      wait_valid("per_v3", 400);
      r0 = rise_cnt;
      repeat (600) @(negedge clk);
      chk("per_stop", rise_cnt - r0, 0);
      chk("per_nval", valid_cnt - v0, 3);
      chk("per_temp", temp, 16'h0FF0);

      // timeout with busy stuck high
      hang = 1'b1;
      pulse_start();
      n = 0;
      while (bus.i2c_ena === 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("to_abort", n, 500);
      chk("to_sbusy", seq_busy, 1);
      m = 0;
      while (seq_busy === 1'b1 && m < 2000) begin
         @(negedge clk);
         m++;
      end
      chk("to_idle", m, 500);
      chk("to_err",  temp_err, 1);
      chk("to_temp", temp, 16'h0FF0);
      hang = 1'b0;
      wait_bus_quiet("to_quiet", 100);

      // reset while in RD_LSB
      msb_v = 8'h55; lsb_v = 8'hAA;
      r0 = rise_cnt;
      pulse_start();
      n = 0;
      while (rise_cnt - r0 < 2 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("rm_reach", rise_cnt - r0, 2);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rm_ena_now", bus.i2c_ena, 0);
      @(negedge clk);
      chk("rm_ena",   bus.i2c_ena, 0);
      chk("rm_temp",  temp, 0);
      chk("rm_err",   temp_err, 0);
      chk("rm_sbusy", seq_busy, 0);
      reset = 1'b0;
      wait_bus_quiet("rm_quiet", 100);
      msb_v = 8'h12; lsb_v = 8'h34;
      pulse_start();
      wait_valid("rm_valid", 300);
      chk("rm_temp2", temp, 16'h1234);
      chk("rm_err2",  temp_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
